// File: rtl/i2s_sample_scheduler_if.sv
// Request/response channel between the sample scheduler and the shared processing engine.
// master = scheduler side, slave = engine side.
interface i2s_sample_scheduler_if #(
    parameter int DAT_WDTH = 24
) ();
    logic                req_valid;
    logic                req_ready;
    logic [DAT_WDTH-1:0] req_data;
    logic                req_chan;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DAT_WDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_data, req_chan, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_chan, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/i2s_sample_scheduler.sv
// Purpose: sends each received stereo frame through a shared engine (left then right) and updates tx as a pair.
// Latency: rx_dump edge -> req_valid next cycle; last response edge -> tx update + frame_done next cycle.
// Backpressure: req held stable until req_ready; frames arriving while busy are dropped and counted.
module i2s_sample_scheduler #(
    parameter int DAT_WDTH = 24,
    parameter int CNT_WDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_dump,
    input  logic [DAT_WDTH-1:0]   rx_left,
    input  logic [DAT_WDTH-1:0]   rx_right,
    input  logic                  tx_load,
    output logic [DAT_WDTH-1:0]   tx_left,
    output logic [DAT_WDTH-1:0]   tx_right,
    input  logic                  bypass,
    i2s_sample_scheduler_if.master eng,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CNT_WDTH-1:0]   overrun_cnt,
    output logic [CNT_WDTH-1:0]   underrun_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_L = 3'd1,
        WAIT_L = 3'd2,
        SEND_R = 3'd3,
        WAIT_R = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DAT_WDTH-1:0] in_right;
    logic [DAT_WDTH-1:0] res_left;
    logic                tx_update;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rx_dump && !bypass)               state_nxt = SEND_L;
            SEND_L:  if (eng.req_valid && eng.req_ready)   state_nxt = WAIT_L;
            WAIT_L:  if (eng.rsp_valid)                    state_nxt = SEND_R;
            SEND_R:  if (eng.req_valid && eng.req_ready)   state_nxt = WAIT_R;
            WAIT_R:  if (eng.rsp_valid)                    state_nxt = IDLE;
            default:                                       state_nxt = IDLE;
        endcase
    end

    // A tx_load coinciding with the pair update latches the new frame, so it is not an underrun.
    assign tx_update = (state == WAIT_R) && eng.rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            eng.req_valid <= 1'b0;
            eng.req_data  <= '0;
            eng.req_chan  <= 1'b0;
            eng.rsp_ready <= 1'b0;
            in_right      <= '0;
            res_left      <= '0;
            tx_left       <= '0;
            tx_right      <= '0;
            frame_done    <= 1'b0;
            overrun_cnt   <= '0;
            underrun_cnt  <= '0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != IDLE);
            eng.req_valid <= (state_nxt == SEND_L) || (state_nxt == SEND_R);
            eng.rsp_ready <= (state_nxt == WAIT_L) || (state_nxt == WAIT_R);
            frame_done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_dump) begin
                        if (bypass) begin
                            tx_left    <= rx_left;
                            tx_right   <= rx_right;
                            frame_done <= 1'b1;
                        end else begin
                            // req_data doubles as the captured left input register.
                            eng.req_data <= rx_left;
                            eng.req_chan <= 1'b0;
                            in_right     <= rx_right;
                        end
                    end
                end
                WAIT_L: begin
                    if (eng.rsp_valid) begin
                        res_left     <= eng.rsp_data;
                        eng.req_data <= in_right;
                        eng.req_chan <= 1'b1;
                    end
                end
                WAIT_R: begin
                    if (eng.rsp_valid) begin
                        tx_left    <= res_left;
                        tx_right   <= eng.rsp_data;
                        frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (rx_dump && busy && (overrun_cnt != '1))
                overrun_cnt <= overrun_cnt + 1'b1;
            if (tx_load && busy && !tx_update && (underrun_cnt != '1))
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Scoreboarded bench for i2s_sample_scheduler with a simple +1 engine model on the request/response channel.
module tb_i2s_sample_scheduler;

    localparam int DW = 24;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_dump;
    logic [DW-1:0] rx_left;
    logic [DW-1:0] rx_right;
    logic          tx_load;
    logic          bypass;
    logic [DW-1:0] tx_left;
    logic [DW-1:0] tx_right;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] overrun_cnt;
    logic [CW-1:0] underrun_cnt;

    i2s_sample_scheduler_if #(.DAT_WDTH(DW)) bus ();

    i2s_sample_scheduler #(.DAT_WDTH(DW), .CNT_WDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_dump      (rx_dump),
        .rx_left      (rx_left),
        .rx_right     (rx_right),
        .tx_load      (tx_load),
        .tx_left      (tx_left),
        .tx_right     (tx_right),
        .bypass       (bypass),
        .eng          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun_cnt  (overrun_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int reqs     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: accepts a request, answers with data+1 when rsp_en allows.
    logic          rdy_en;
    logic          rsp_en;
    logic          pend;
    logic [DW-1:0] eng_dat;

    assign bus.req_ready = rdy_en;
    assign bus.rsp_valid = pend & rsp_en;
    assign bus.rsp_data  = eng_dat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            eng_dat <= '0;
        end else if (bus.req_valid && bus.req_ready) begin
            pend    <= 1'b1;
            eng_dat <= bus.req_data + 24'd1;
            reqs    <= reqs + 1;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            pend    <= 1'b0;
        end
    end

    // Scoreboard: expected tx pair and the cycle frame_done should be seen (-1 = any).
    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            c;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    logic [DW-1:0] prev_l = '0;
    logic [DW-1:0] prev_r = '0;
    logic          rst_seen = 1'b0;

    always @(negedge rst_n) rst_seen = 1'b1;

    always @(negedge clk) begin
        if (rst_seen) begin
            rst_seen = 1'b0;
            prev_l   = tx_left;
            prev_r   = tx_right;
        end
        if (rst_n && frame_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("tx_left", {8'h0, tx_left}, {8'h0, e.l});
                chk("tx_right", {8'h0, tx_right}, {8'h0, e.r});
                if (e.c >= 0) chk("frame_latency", cyc, e.c);
            end
        end else if (rst_n) begin
            chk("tx_stable", {tx_left, 8'h0} ^ {prev_l, 8'h0}, 32'd0);
            chk("tx_stable_r", {8'h0, tx_right} ^ {8'h0, prev_r}, 32'd0);
        end
        prev_l = tx_left;
        prev_r = tx_right;
    end

    task automatic dump(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic byp,
                        input bit push, input logic [DW-1:0] el, input logic [DW-1:0] er, input int off);
        exp_t x;
        @(negedge clk);
        rx_left  = l;
        rx_right = r;
        bypass   = byp;
        rx_dump  = 1'b1;
        if (push) begin
            x.l = el;
            x.r = er;
            x.c = (off < 0) ? -1 : cyc + 1 + off;
            sbq.push_back(x);
        end
        @(negedge clk);
        rx_dump = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        chk(nm, {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int r0;
        rst_n = 1'b0; rx_dump = 1'b0; rx_left = '0; rx_right = '0;
        tx_load = 1'b0; bypass = 1'b0; rdy_en = 1'b1; rsp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_left", {8'h0, tx_left}, 32'd0);
        chk("rst_tx_right", {8'h0, tx_right}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("rst_rsp_ready", {31'd0, bus.rsp_ready}, 32'd0);
        chk("rst_cnts", {28'd0, overrun_cnt, underrun_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, zero wait states.
        dump(24'h123456, 24'hABCDEF, 1'b0, 1'b1, 24'h123457, 24'hABCDF0, 4);
        chk("req_valid_n1", {31'd0, bus.req_valid}, 32'd1);
        wait_idle("idle_basic");

        // Engine stalls request acceptance for 10 cycles.
        rdy_en = 1'b0;
        r0 = reqs;
        dump(24'h123456, 24'hABCDEF, 1'b0, 1'b1, 24'h123457, 24'hABCDF0, -1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_req_valid", {31'd0, bus.req_valid}, 32'd1);
            chk("stall_req_data", {8'h0, bus.req_data}, 32'h00123456);
            chk("stall_req_chan", {31'd0, bus.req_chan}, 32'd0);
            @(negedge clk);
        end
        rdy_en = 1'b1;
        wait_idle("idle_stall");
        chk("stall_req_count", reqs - r0, 32'd2);

        // Second frame arrives during WAIT_L and is dropped.
        rsp_en = 1'b0;
        dump(24'h000010, 24'h000020, 1'b0, 1'b1, 24'h000011, 24'h000021, -1);
        dump(24'h777777, 24'h888888, 1'b0, 1'b0, 24'h0, 24'h0, -1);
        chk("overrun_1", {30'd0, overrun_cnt}, 32'd1);
        rsp_en = 1'b1;
        wait_idle("idle_overrun");

        // Underruns while stalled in SEND_R, then saturation of both counters.
        dump(24'h000100, 24'h000200, 1'b0, 1'b1, 24'h000101, 24'h000201, -1);
        @(negedge clk);
        rdy_en = 1'b0;
        @(negedge clk);
        chk("sendr_chan", {31'd0, bus.req_chan}, 32'd1);
        chk("sendr_data", {8'h0, bus.req_data}, 32'h00000200);
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        chk("underrun_1", {30'd0, underrun_cnt}, 32'd1);
        chk("underrun_hold_l", {8'h0, tx_left}, 32'h00000011);
        tx_load = 1'b1;
        repeat (4) @(negedge clk);
        tx_load = 1'b0;
        chk("underrun_sat", {30'd0, underrun_cnt}, 32'd3);
        for (int i = 0; i < 3; i++)
            dump(24'h0, 24'h0, 1'b0, 1'b0, 24'h0, 24'h0, -1);
        chk("overrun_sat", {30'd0, overrun_cnt}, 32'd3);
        rdy_en = 1'b1;
        wait_idle("idle_underrun");

        // Bypass frame: no engine traffic.
        r0 = reqs;
        dump(24'h000001, 24'hFFFFFF, 1'b1, 1'b1, 24'h000001, 24'hFFFFFF, 0);
        chk("bypass_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        chk("bypass_no_req", reqs - r0, 32'd0);

        // bypass toggled mid-frame has no effect.
        dump(24'h000005, 24'h000006, 1'b0, 1'b1, 24'h000006, 24'h000007, 4);
        bypass = 1'b1;
        wait_idle("idle_midbypass");
        bypass = 1'b0;

        // Asynchronous reset during WAIT_R abandons the frame.
        dump(24'h000300, 24'h000400, 1'b0, 1'b0, 24'h0, 24'h0, -1);
        @(negedge clk);
        @(negedge clk);
        rsp_en = 1'b0;
        @(negedge clk);
        chk("waitr_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", {8'h0, tx_left | tx_right}, 32'd0);
        chk("arst_cnts", {28'd0, overrun_cnt, underrun_cnt}, 32'd0);
        chk("arst_ctl", {28'd0, busy, frame_done, bus.req_valid, bus.rsp_ready}, 32'd0);
        #1 rst_n = 1'b1;
        rsp_en = 1'b1;
        dump(24'h000AAA, 24'h000BBB, 1'b0, 1'b1, 24'h000AAB, 24'h000BBC, 4);
        wait_idle("idle_after_rst");

        // tx_load on the update edge is not an underrun.
        dump(24'h000001, 24'h000002, 1'b0, 1'b1, 24'h000002, 24'h000003, 4);
        repeat (3) @(negedge clk);
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        chk("no_underrun_on_update", {30'd0, underrun_cnt}, 32'd0);
        wait_idle("idle_final");

        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_sample_scheduler.md
I2S_SAMPLE_SCHEDULER -- requirements
Module: i2s_sample_scheduler

Interface
REQ-001 The block SHALL have parameter DAT_WDTH, default 24, giving the audio sample width.
REQ-002 The block SHALL have parameter CNT_WDTH, default 16, giving the status counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_dump, input, 1 bit: one-cycle pulse marking rx_left/rx_right as a new valid frame.
REQ-006 The block SHALL have ports rx_left and rx_right, input, DAT_WDTH each: received left and right samples.
REQ-007 The block SHALL have port tx_load, input, 1 bit: one-cycle pulse marking when the transmitter latches tx_left/tx_right.
REQ-008 The block SHALL have ports tx_left and tx_right, output, DAT_WDTH each: registered samples presented to the transmitter.
REQ-009 The block SHALL have port bypass, input, 1 bit: 1 routes frames rx to tx without processing.
REQ-010 The block SHALL have ports req_valid (output, 1), req_ready (input, 1), req_data (output, DAT_WDTH) and req_chan (output, 1; 0 = left, 1 = right): the request channel to the shared processing engine.
REQ-011 The block SHALL have ports rsp_valid (input, 1), rsp_ready (output, 1) and rsp_data (input, DAT_WDTH): the response channel from the engine.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when tx_left/tx_right are updated.
REQ-014 The block SHALL have ports overrun_cnt and underrun_cnt, output, CNT_WDTH each: saturating event counters.

Function
REQ-015 The FSM SHALL have states IDLE, SEND_L, WAIT_L, SEND_R and WAIT_R.
REQ-016 IDLE with rx_dump=1 and bypass=0: capture rx_left/rx_right into input registers and go to SEND_L on the next cycle.
REQ-017 IDLE with rx_dump=1 and bypass=1: load tx_left/tx_right directly from rx_left/rx_right at that edge, pulse frame_done, stay in IDLE.
REQ-018 SEND_L: req_valid=1, req_chan=0, req_data=captured left; on req_valid and req_ready, go to WAIT_L.
REQ-019 WAIT_L: rsp_ready=1; on rsp_valid, store rsp_data as the left result and go to SEND_R.
REQ-020 SEND_R and WAIT_R: same as SEND_L and WAIT_L with req_chan=1 and the right sample.
REQ-021 WAIT_R with rsp_valid=1: at that edge, load tx_left (stored left result) and tx_right (rsp_data) together, pulse frame_done next cycle, and return to IDLE.
REQ-022 req_data and req_chan SHALL be stable while req_valid=1 and req_ready=0; req_valid SHALL never deassert before acceptance.
REQ-023 req_valid SHALL be 0 outside SEND states, and rsp_ready SHALL be 0 outside WAIT states; rsp_valid outside WAIT states SHALL be ignored.
REQ-024 Latency: rx_dump at cycle N gives req_valid=1 at N+1, with zero wait states.
REQ-025 Latency: the final response accepted at cycle M gives tx_left/tx_right updated and frame_done=1 at M+1.
REQ-026 rx_dump while busy=1 (including the WAIT_R completion cycle) SHALL drop the frame and increment overrun_cnt by 1.
REQ-027 tx_load while busy=1 SHALL increment underrun_cnt by 1; tx_left/tx_right hold the previous frame.
REQ-028 tx_load in the same cycle as a tx_left/tx_right update SHALL NOT count as underrun.
REQ-029 Both counters SHALL saturate at 2^CNT_WDTH-1 and SHALL NOT wrap.
REQ-030 bypass SHALL be sampled only in IDLE on rx_dump; a change mid-frame SHALL NOT affect the frame in flight.
REQ-031 tx_left/tx_right SHALL change only in a frame_done update cycle and SHALL never show a mixed old/new pair.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE and set all outputs and internal registers to 0, including tx_left, tx_right, both counters, req_valid, rsp_ready, busy and frame_done.
REQ-033 Reset asserted mid-frame SHALL abandon the frame without completing it; the first rx_dump after rst_n rises starts a fresh frame.

Verification
REQ-034 bypass=0, rx_left=0x123456, rx_right=0xABCDEF, engine returns input+1 with req_ready and rsp_valid each held 1 -> tx_left=0x123457, tx_right=0xABCDF0, frame_done pulses once, 4 cycles after rx_dump.
REQ-035 Engine stalls req_ready=0 for 10 cycles in SEND_L -> req_data=0x123456 and req_chan=0 stable throughout; one request accepted; no duplicate.
REQ-036 Second rx_dump arrives while in WAIT_L -> overrun_cnt=1, and the first frame completes with its original data.
REQ-037 tx_load while in SEND_R -> underrun_cnt=1, tx outputs unchanged; with CNT_WDTH=2, five underruns -> underrun_cnt=3.
REQ-038 bypass=1, rx_dump with 0x000001 / 0xFFFFFF -> tx_left/tx_right equal those values next cycle, req_valid never asserted.
REQ-039 rst_n pulsed low during WAIT_R -> all outputs 0 immediately, without a clock edge; the next frame completes normally.
